// File: rtl/comma_aligner.sv
// Serial-to-parallel front end: hunts for the K28.5 comma, confirms the symbol
// boundary over repeated aligned commas, then emits aligned 10-bit symbols.
module comma_aligner #(
    parameter int SYM_W    = 10,
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_valid,
    output logic             locked,
    output logic             realign
);
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);
    localparam logic [SYM_W-1:0] K285_RDN = 10'b0011111010;
    localparam logic [SYM_W-1:0] K285_RDP = 10'b1100000101;

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [SYM_W-2:0] sr_q, sr_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [CW-1:0]    ccnt_q, ccnt_d;
    logic [MW-1:0]    mcnt_q, mcnt_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic             sv_q, sv_d;
    logic             lk_q, lk_d;
    logic             rl_q, rl_d;

    logic [SYM_W-1:0] win;
    logic             comma, boundary;
    logic [3:0]       bcnt_inc;

    assign win      = {sr_q, bit_in};
    assign comma    = (win == K285_RDN) || (win == K285_RDP);
    assign boundary = (bcnt_q == 4'd9);
    assign bcnt_inc = boundary ? 4'd0 : bcnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= HUNT;
            sr_q    <= '0;
            bcnt_q  <= '0;
            ccnt_q  <= '0;
            mcnt_q  <= '0;
            sym_q   <= '0;
            sv_q    <= 1'b0;
            lk_q    <= 1'b0;
            rl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            ccnt_q  <= ccnt_d;
            mcnt_q  <= mcnt_d;
            sym_q   <= sym_d;
            sv_q    <= sv_d;
            lk_q    <= lk_d;
            rl_q    <= rl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bcnt_d  = bcnt_q;
        ccnt_d  = ccnt_q;
        mcnt_d  = mcnt_q;
        sym_d   = sym_q;
        sv_d    = 1'b0;
        rl_d    = 1'b0;
        if (bit_valid) begin
            sr_d = win[SYM_W-2:0];
            case (state_q)
                HUNT: begin
                    bcnt_d = '0;
                    if (comma) begin
                        ccnt_d = CW'(1);
                        if (LOCK_CNT == 1) begin
                            state_d = LOCKED;
                            mcnt_d  = '0;
                            sym_d   = win;
                            sv_d    = 1'b1;
                        end else begin
                            state_d = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    bcnt_d = bcnt_inc;
                    if (comma && boundary) begin
                        ccnt_d = ccnt_q + CW'(1);
                        if (int'(ccnt_q) + 1 == LOCK_CNT) begin
                            state_d = LOCKED;
                            mcnt_d  = '0;
                            sym_d   = win;
                            sv_d    = 1'b1;
                        end
                    end else if (comma) begin
                        // Comma at a new phase: restart confirmation from it.
                        bcnt_d = '0;
                        ccnt_d = CW'(1);
                    end
                end
                LOCKED: begin
                    bcnt_d = bcnt_inc;
                    if (boundary) begin
                        sym_d = win;
                        sv_d  = 1'b1;
                    end
                    if (comma && boundary) begin
                        mcnt_d = '0;
                    end else if (comma) begin
                        if (int'(mcnt_q) + 1 == LOSS_CNT) begin
                            state_d = HUNT;
                            rl_d    = 1'b1;
                            ccnt_d  = '0;
                            mcnt_d  = '0;
                            bcnt_d  = '0;
                        end else begin
                            mcnt_d = mcnt_q + MW'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        lk_d = (state_d == LOCKED);
    end

    assign sym_out   = sym_q;
    assign sym_valid = sv_q;
    assign locked    = lk_q;
    assign realign   = rl_q;
endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: a bit-index based reference model is checked
// against the DUT every cycle, plus literal expectations per scenario.
module tb_comma_aligner;
    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 4;
    localparam logic [9:0] KN   = 10'b0011111010;
    localparam logic [9:0] KP   = 10'b1100000101;
    localparam logic [9:0] D215 = 10'b1010101010;
    localparam logic [9:0] D102 = 10'b0101010101;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [9:0] sym_out;
    logic       sym_valid, locked, realign;

    comma_aligner #(.SYM_W(10), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .sym_out(sym_out), .sym_valid(sym_valid), .locked(locked), .realign(realign)
    );

    always #5 clk = ~clk;

    int  nchk = 0;
    int  nerr = 0;
    bit  chk_en = 1'b0;

    // Reference model: tracks the absolute index of valid bits and the index of
    // the comma that defined the current phase; alignment is (n - anchor) % 10.
    logic [9:0] m_hist;
    int         m_n, m_anchor, m_cc, m_miss;
    bit         m_lk, m_have, m_sv, m_rl;
    logic [9:0] m_sym;

    logic [9:0] strobes[$];
    int         rl_cnt = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(bit b, bit v, bit r);
        bit comma, al;
        if (!r) begin
            m_hist = '0; m_n = 0; m_anchor = 0; m_cc = 0; m_miss = 0;
            m_lk = 0; m_have = 0; m_sv = 0; m_rl = 0; m_sym = '0;
            return;
        end
        m_sv = 0;
        m_rl = 0;
        if (!v) return;
        m_hist = {m_hist[8:0], b};
        comma  = (m_hist == KN) || (m_hist == KP);
        al     = m_have && ((m_n - m_anchor) % 10 == 0);
        if (m_lk) begin
            if (al) begin m_sym = m_hist; m_sv = 1; end
            if (comma) begin
                if (al) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin
                        m_lk = 0; m_have = 0; m_miss = 0; m_cc = 0; m_rl = 1;
                    end
                end
            end
        end else if (comma) begin
            if (al) m_cc++;
            else begin m_anchor = m_n; m_have = 1; m_cc = 1; end
            if (m_cc == LOCK_CNT) begin m_lk = 1; m_miss = 0; m_sym = m_hist; m_sv = 1; end
        end
        m_n++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sym_valid", sym_valid, m_sv);
            chk("sym_out",   sym_out,   m_sym);
            chk("locked",    locked,    m_lk);
            chk("realign",   realign,   m_rl);
            if (sym_valid) strobes.push_back(sym_out);
            if (realign) rl_cnt++;
        end
    end

    task automatic step(bit b, bit v, bit r);
        bit_in = b; bit_valid = v; rst = r;
        @(posedge clk);
        model(b, v, r);
        #1;
    endtask

    task automatic sendbits(logic [9:0] s, int n, bit gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(s[i], 1'b1, 1'b1);
            if (gap) step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
    endtask

    task automatic send(logic [9:0] s, bit gap);
        sendbits(s, 10, gap);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        settle();
        strobes.delete();
        rl_cnt = 0;
    endtask

    task automatic acquire(bit gap, string tag);
        do_reset();
        sendbits(10'b0001010101, 7, gap);
        send(KN, gap); send(D215, gap); send(KP, gap); send(D102, gap);
        settle();
        chk({tag, "_prelock_strobes"}, strobes.size(), 0);
        chk({tag, "_prelock_locked"}, locked, 0);
        send(KN, gap); send(D215, gap);
        settle();
        chk({tag, "_strobes"}, strobes.size(), 2);
        if (strobes.size() >= 2) begin
            chk({tag, "_sym0"}, strobes[0], KN);
            chk({tag, "_sym1"}, strobes[1], D215);
        end
        chk({tag, "_locked"}, locked, 1);
    endtask

    initial begin
        // Reset held for three cycles with random data
        step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        chk_en = 1'b1;
        step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        settle();
        chk("reset_locked", locked, 0);
        chk("reset_sym_out", sym_out, 0);

        acquire(1'b0, "acq");
        acquire(1'b1, "gap");

        // Confirmation restart at a shifted phase
        do_reset();
        send(KN, 0); send(D215, 0); send(KP, 0);
        chk("restart_cc2", m_cc, 2);
        step(1'b0, 1'b1, 1'b1);
        send(KN, 0);
        chk("restart_cc1", m_cc, 1);
        send(D215, 0); send(KP, 0);
        settle();
        chk("restart_nolock", locked, 0);
        send(D102, 0); send(KN, 0);
        settle();
        chk("restart_lock", locked, 1);
        chk("restart_strobes", strobes.size(), 1);

        // Loss of lock after four misaligned commas
        step(1'b0, 1'b1, 1'b1);
        send(KN, 0); send(D215, 0); send(KN, 0); send(D215, 0); send(KN, 0);
        settle();
        chk("loss_3miss_locked", locked, 1);
        chk("loss_3miss_rl", rl_cnt, 0);
        send(D215, 0); send(KN, 0);
        settle();
        chk("loss_locked", locked, 0);
        chk("loss_rl", rl_cnt, 1);
        send(D215, 0); send(KN, 0); send(D215, 0); send(KN, 0); send(D215, 0);
        settle();
        chk("relock_pending", locked, 0);
        send(KN, 0);
        settle();
        chk("relock", locked, 1);

        // An aligned comma between misses clears the miss count
        step(1'b0, 1'b1, 1'b1);
        send(KN, 0); send(D215, 0); send(KN, 0); send(D215, 0); send(KN, 0);
        chk("miss3_model", m_miss, 3);
        sendbits(10'b0101010101, 9, 1'b0);
        send(KN, 0);
        chk("miss_clear_model", m_miss, 0);
        step(1'b0, 1'b1, 1'b1);
        send(KN, 0); send(D215, 0); send(KN, 0); send(D215, 0); send(KN, 0);
        settle();
        chk("noloss_locked", locked, 1);
        chk("noloss_rl", rl_cnt, 1);

        // Reset while locked
        step(1'b1, 1'b1, 1'b0);
        settle();
        chk("midrst_locked", locked, 0);
        chk("midrst_sym_out", sym_out, 0);
        chk("midrst_sym_valid", sym_valid, 0);
        strobes.delete();
        send(KN, 0); send(D215, 0); send(KN, 0); send(D215, 0);
        settle();
        chk("midrst_relock_pending", locked, 0);
        send(KN, 0);
        settle();
        chk("midrst_relock", locked, 1);
        chk("midrst_strobes", strobes.size(), 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/comma_aligner.md
Name: comma_aligner

Overview:
- Serial-to-parallel front end of the PCIe receive symbol path.
- Shifts in recovered serial bits and hunts for the K28.5 comma to find the 10-bit symbol boundary.
- After repeated aligned commas confirm the boundary, emits aligned 10-bit symbols with a one-cycle valid strobe.
- Sits directly upstream of the running-disparity checker, whose data_in is driven by sym_out.

Parameters:
- SYM_W, 10: symbol width; fixed at 10 for 8b/10b. Other values are unsupported.
- LOCK_CNT, 3: consecutive boundary-aligned commas required to reach LOCKED. Must be >= 1.
- LOSS_CNT, 4: misaligned commas seen while LOCKED, with no aligned comma in between, that force re-hunt. Must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- bit_in  input  1  serial data bit; first-transmitted bit (a) arrives first.
- bit_valid  input  1  bit_in qualifier; when low, all state holds.
- sym_out  output  SYM_W  aligned symbol; bit a in sym_out[9], bit j in sym_out[0].
- sym_valid  output  1  one-cycle strobe: sym_out carries a new symbol.
- locked  output  1  high while in LOCKED.
- realign  output  1  one-cycle pulse on the LOCKED->HUNT transition.

Behaviour:
- Reset: when rst=0 at a clk edge:
  - state=HUNT.
  - Shift register sr=0, bit counter bcnt=0, comma counter ccnt=0, miss counter mcnt=0.
  - sym_out=0, sym_valid=0, locked=0, realign=0.
  - Reset mid-operation has the same effect; locked drops on that edge.
- Window: win = {sr[8:0], bit_in}, combinational. On each bit_valid=1 edge, sr <= win.
- Comma: win == 10'b0011111010 (K28.5 RD-) or win == 10'b1100000101 (K28.5 RD+). Commas are evaluated only when bit_valid=1.
- Boundary: bcnt counts valid bits 0..9 and wraps. A boundary bit is a valid bit with bcnt==9. Aligned comma = comma on a boundary bit. Misaligned comma = comma on any other bit.
- bit_valid=0: sr, bcnt, counters and state hold; sym_valid=0; realign=0; sym_out holds.
- HUNT:
  - On a comma: bcnt<=0, ccnt<=1, go to CONFIRM. If LOCK_CNT==1, go directly to LOCKED and emit that comma (sym_valid=1).
  - Otherwise bcnt is don't-care (kept 0); no outputs.
- CONFIRM (no symbol output):
  - Each valid bit: bcnt increments, wrapping 9->0.
  - Aligned comma: ccnt+1. When ccnt+1==LOCK_CNT, go to LOCKED, mcnt<=0, and emit this comma on the same edge (sym_out=win, sym_valid=1).
  - Misaligned comma: restart at the new phase (bcnt<=0, ccnt<=1), stay in CONFIRM.
  - Non-comma at a boundary: no change.
- LOCKED:
  - Every boundary bit: sym_out<=win, sym_valid<=1 for one cycle. Latency is one clk edge after the tenth bit is presented.
  - Aligned comma: mcnt<=0.
  - Misaligned comma: mcnt+1. If mcnt+1==LOSS_CNT, go to HUNT with locked<=0, realign<=1 for one cycle, ccnt<=0, mcnt<=0. No symbol is emitted on that edge unless it is also a boundary bit; if so, the symbol is still emitted.
- locked is registered and equals (state==LOCKED).
- Counter widths: ccnt is $clog2(LOCK_CNT+1) bits, mcnt is $clog2(LOSS_CNT+1) bits, bcnt is 4 bits. No counter overflows, because each resets at its terminal value.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random bit_in and bit_valid=1. Required: locked=0, sym_valid=0, sym_out=0, realign=0 every cycle.
- Acquire (LOCK_CNT=3): send 7 junk bits, then K28.5- 0011111010, D21.5 1010101010, K28.5+ 1100000101, D10.2 0101010101, K28.5- 0011111010, D21.5. Required:
  - locked rises with a sym_valid strobe on the third comma, sym_out=0011111010.
  - The next strobe has sym_out=1010101010.
  - No strobe occurs before lock.
- Gapped input: repeat the acquire scenario with bit_valid toggling 1,0,1,0. Required: identical symbol sequence; each strobe occurs exactly one edge after the tenth valid bit; no strobe on bit_valid=0 cycles.
- CONFIRM restart: after 2 aligned commas, insert one extra bit and send commas at the new phase. Required:
  - The misaligned comma resets ccnt to 1.
  - Lock occurs after 2 further aligned commas at the new phase.
- Loss of lock (LOSS_CNT=4): when LOCKED, slip one bit and send 4 commas at the shifted phase. Required:
  - realign pulses once on the 4th misaligned comma, and locked falls on the same edge.
  - Re-lock occurs after 3 aligned commas at the new phase.
  - An aligned comma between misses resets mcnt, so no loss occurs.
- Reset mid-lock: drive rst=0 for one cycle while LOCKED. Required: next cycle locked=0, sym_valid=0, sym_out=0; re-acquisition needs 3 fresh commas.
